mem_access_stage: RTL
=====================

// Module: mem_access_stage
// PURPOSE
//  Memory (M) stage of the pipelined core: EX->M pipeline register plus a data-memory
//  bus master with req/ack handshake. Feeds the M->W write-back register directly.
//  Stalls the upstream pipeline while a load/store waits for memAck.
//  Inserts a write-back bubble (regWriteM=0) on every stall cycle.
// PARAMETERS
//  M  32  data/address width
//  N  5   register-index width
// PORTS
//  CLK        in   1  clock, all state updates on rising edge
//  RST        in   1  asynchronous, active-high reset
//  regWriteE  in   1  EX: instruction writes a register
//  memToRegE  in   1  EX: write-back selects memory data
//  memReadE   in   1  EX: load
//  memWriteE  in   1  EX: store
//  ALUE       in   M  EX: ALU result / effective address
//  writeDataE in   M  EX: store data
//  writeRE    in   N  EX: destination register
//  pcPlusE    in   M  EX: PC+4 of instruction
//  memReq     out  1  bus request, high for the whole access
//  memWe      out  1  bus write enable (valid while memReq)
//  memAddr    out  M  bus address (= ALUM)
//  memWData   out  M  bus write data
//  memRData   in   M  bus read data, sampled when memAck=1
//  memAck     in   1  bus completion, single-cycle pulse
//  stallM     out  1  freeze IF/ID/EX and this stage's input latch
//  RD         out  M  load data to write-back register
//  ALUM       out  M  latched ALU result
//  writeRM    out  N  latched destination register
//  pcPlusM    out  M  latched PC+4
//  regWriteM  out  1  register write, gated (0 during stall)
//  memToRegM  out  1  latched write-back select
// BEHAVIOUR
//  Reset (async, RST=1): all latched fields, RD, state cleared to 0/IDLE; so memReq=0,
//   memWe=0, stallM=0, regWriteM=0, all data outputs 0. RST mid-access aborts it
//   immediately (memReq drops same instant); no write-back of the aborted op.
//  Input latch: at posedge CLK with stallM=0, capture all *E inputs; with stallM=1, hold.
//  FSM states: IDLE, BUSY.
//   IDLE: stallM=0, memReq=0. At an edge that captures an instruction with
//    memReadE|memWriteE=1 -> BUSY next cycle; else stay IDLE.
//   BUSY: stallM=1, memReq=1, memAddr=ALUM, memWData=latched writeData,
//    memWe=latched memWrite. memAck=1 at an edge -> IDLE; else stay BUSY (no timeout).
//  RD: at ack edge of a load, RD<=memRData; at capture of a non-load, RD<=0; else holds.
//  memRead & memWrite both set: treated as store (memWe=1), RD<=0.
//  regWriteM = latched regWrite & (state==IDLE); memToRegM, ALUM, writeRM, pcPlusM pass
//   latched values ungated.
//  Latency: non-memory op -> outputs valid the cycle after capture, no stall.
//   Memory op acked after k>=1 BUSY cycles -> stallM high exactly k cycles, outputs
//   (incl. RD) valid in the first IDLE cycle after; next instruction captured at that
//   cycle's closing edge. Back-to-back memory ops re-enter BUSY with no idle gap beyond that one cycle.
//  memAck while IDLE: ignored. memRData ignored unless memAck in BUSY during a load.
//  Arithmetic: none; all widths pass through unchanged.
// TESTING
//  1 RST pulse mid-BUSY (memReq=1) -> memReq, stallM, regWriteM drop to 0 asynchronously; state IDLE.
//  2 ALU op (regWriteE=1, ALUE=0x0000_0010, writeRE=5) -> next cycle ALUM=0x10, writeRM=5,
//    regWriteM=1, RD=0, stallM never asserted.
//  3 Load ALUE=0x40, memAck after 3 cycles with memRData=0xDEAD_BEEF -> stallM high 3 cycles,
//    memAddr=0x40, memWe=0, regWriteM=0 while stalled; then RD=0xDEAD_BEEF, regWriteM=1.
//  4 Store ALUE=0x80, writeDataE=0x1234, ack after 1 cycle -> memWe=1, memWData=0x1234,
//    stallM high 1 cycle, RD=0; upstream inputs changed during stall are not captured.
//  5 Back-to-back loads, acks after 1 and 2 cycles -> each RD correct, stall 1 then 2 cycles.
//  6 memAck pulse while IDLE and memRead&memWrite both set -> ack ignored; op issued as store.

Source files
------------

// File: rtl/mem_access_stage.sv
// Memory stage: EX->M pipeline register plus a req/ack data-bus master.
// Holds the upstream pipeline while a load or store waits for its ack.
module mem_access_stage #(
    parameter int M = 32,
    parameter int N = 5
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         regWriteE,
    input  logic         memToRegE,
    input  logic         memReadE,
    input  logic         memWriteE,
    input  logic [M-1:0] ALUE,
    input  logic [M-1:0] writeDataE,
    input  logic [N-1:0] writeRE,
    input  logic [M-1:0] pcPlusE,
    output logic         memReq,
    output logic         memWe,
    output logic [M-1:0] memAddr,
    output logic [M-1:0] memWData,
    input  logic [M-1:0] memRData,
    input  logic         memAck,
    output logic         stallM,
    output logic [M-1:0] RD,
    output logic [M-1:0] ALUM,
    output logic [N-1:0] writeRM,
    output logic [M-1:0] pcPlusM,
    output logic         regWriteM,
    output logic         memToRegM
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t       state;
    state_t       state_next;
    logic         reg_write;
    logic         mem_read;
    logic         mem_write;
    logic [M-1:0] write_data;
    logic         capture;
    logic         is_load;

    assign capture = (state == IDLE);
    // A simultaneous read+write is issued as a store, so it never loads.
    assign is_load = mem_read & ~mem_write;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            reg_write  <= 1'b0;
            memToRegM  <= 1'b0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            ALUM       <= '0;
            write_data <= '0;
            writeRM    <= '0;
            pcPlusM    <= '0;
            RD         <= '0;
        end else begin
            state <= state_next;
            if (capture) begin
                reg_write  <= regWriteE;
                memToRegM  <= memToRegE;
                mem_read   <= memReadE;
                mem_write  <= memWriteE;
                ALUM       <= ALUE;
                write_data <= writeDataE;
                writeRM    <= writeRE;
                pcPlusM    <= pcPlusE;
                if (!(memReadE && !memWriteE))
                    RD <= '0;
            end else if (memAck && is_load) begin
                RD <= memRData;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (memReadE || memWriteE) state_next = BUSY;
            BUSY: if (memAck) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign stallM    = (state == BUSY);
    assign memReq    = (state == BUSY);
    assign memWe     = (state == BUSY) & mem_write;
    assign memAddr   = ALUM;
    assign memWData  = write_data;
    assign regWriteM = reg_write & (state == IDLE);

endmodule
